// File: rtl/plru_replace_array.sv
// Per-set tree pseudo-LRU store: reports the victim/hit way on each lookup and
// makes that way MRU; invalidates make a way LRU when no lookup is in progress.
module plru_replace_array #(
   parameter int unsigned NumSets = 16,
   parameter int unsigned NumWays = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid_i,
   input  logic [$clog2(NumSets)-1:0] req_set_i,
   input  logic                       req_hit_i,
   input  logic [$clog2(NumWays)-1:0] req_way_i,
   input  logic                       inv_valid_i,
   input  logic [$clog2(NumSets)-1:0] inv_set_i,
   input  logic [$clog2(NumWays)-1:0] inv_way_i,
   output logic                       inv_ready_o,
   output logic                       resp_valid_o,
   output logic [$clog2(NumWays)-1:0] resp_way_o,
   output logic [NumWays-2:0]         resp_tree_o
);

   localparam int unsigned Levels = $clog2(NumWays);
   localparam int unsigned SetW   = $clog2(NumSets);
   localparam int unsigned TreeW  = NumWays - 1;

   // Force every node on way's path: to the way's bit (MRU) or its inverse (LRU).
   function automatic logic [TreeW-1:0] set_path(input logic [TreeW-1:0] tree_in,
                                                  input logic [Levels-1:0] way,
                                                  input logic              make_lru);
      logic [TreeW-1:0] tree_out;
      int unsigned      node;
      tree_out = tree_in;
      node     = 0;
      for (int l = 0; l < Levels; l++) begin
         tree_out[node] = way[Levels-1-l] ^ make_lru;
         node = way[Levels-1-l] ? 2 * node + 2 : 2 * node + 1;
      end
      return tree_out;
   endfunction

   logic [TreeW-1:0]  tree_q [NumSets];
   logic [TreeW-1:0]  rd_tree;
   logic [Levels-1:0] victim;
   logic [Levels-1:0] chosen;
   logic [TreeW-1:0]  mru_tree;
   logic [TreeW-1:0]  lru_tree;
   logic              wr_en;
   logic [SetW-1:0]   wr_set;
   logic [TreeW-1:0]  wr_tree;

   logic              resp_valid_d, resp_valid_q;
   logic [Levels-1:0] resp_way_d, resp_way_q;
   logic [TreeW-1:0]  resp_tree_d, resp_tree_q;

   always_comb begin
      int unsigned node;
      rd_tree = tree_q[req_set_i];
      victim  = '0;
      node    = 0;
      for (int l = 0; l < Levels; l++) begin
         victim[Levels-1-l] = ~rd_tree[node];
         node = victim[Levels-1-l] ? 2 * node + 2 : 2 * node + 1;
      end
      chosen   = req_hit_i ? req_way_i : victim;
      mru_tree = set_path(rd_tree, chosen, 1'b0);
      lru_tree = set_path(tree_q[inv_set_i], inv_way_i, 1'b1);
   end

   // Lookups take priority, so at most one tree is written per cycle.
   assign inv_ready_o = ~req_valid_i;

   always_comb begin
      wr_en   = req_valid_i | inv_valid_i;
      wr_set  = req_valid_i ? req_set_i : inv_set_i;
      wr_tree = req_valid_i ? mru_tree : lru_tree;
   end

   always_comb begin
      resp_valid_d = req_valid_i;
      resp_way_d   = resp_way_q;
      resp_tree_d  = resp_tree_q;
      if (req_valid_i) begin
         resp_way_d  = chosen;
         resp_tree_d = mru_tree;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NumSets; s++) begin
            tree_q[s] <= '1;
         end
      end else if (wr_en) begin
         tree_q[wr_set] <= wr_tree;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid_q <= 1'b0;
         resp_way_q   <= '0;
         resp_tree_q  <= '1;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_way_q   <= resp_way_d;
         resp_tree_q  <= resp_tree_d;
      end
   end

   assign resp_valid_o = resp_valid_q;
   assign resp_way_o   = resp_way_q;
   assign resp_tree_o  = resp_tree_q;

endmodule

// File: tb/tb_plru_replace_array.sv
// Directed scoreboard bench for plru_replace_array: stimulus pushes expected
// responses, a negedge monitor pops and compares them.
module tb_plru_replace_array;

   localparam int unsigned NumSets = 16;
   localparam int unsigned NumWays = 8;

   typedef struct {
      logic [2:0] way;
      logic [6:0] tree;
      bit         chk_tree;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic [3:0] req_set;
   logic       req_hit;
   logic [2:0] req_way;
   logic       inv_valid;
   logic [3:0] inv_set;
   logic [2:0] inv_way;
   logic       inv_ready;
   logic       resp_valid;
   logic [2:0] resp_way;
   logic [6:0] resp_tree;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   plru_replace_array #(
      .NumSets(NumSets),
      .NumWays(NumWays)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_set_i   (req_set),
      .req_hit_i   (req_hit),
      .req_way_i   (req_way),
      .inv_valid_i (inv_valid),
      .inv_set_i   (inv_set),
      .inv_way_i   (inv_way),
      .inv_ready_o (inv_ready),
      .resp_valid_o(resp_valid),
      .resp_way_o  (resp_way),
      .resp_tree_o (resp_tree)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: every presented response must match the oldest expectation.
   always @(negedge clk) begin
      if (resp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_resp: got way %0d, expected no response", resp_way);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("resp_way", 32'(resp_way), 32'(e.way));
            if (e.chk_tree) check("resp_tree", 32'(resp_tree), 32'(e.tree));
         end
      end
   end

   task automatic lookup(input logic [3:0] set, input logic hit, input logic [2:0] way,
                         input logic [2:0] exp_way, input bit chk_tree = 0,
                         input logic [6:0] exp_tree = '0);
      exp_t e;
      @(negedge clk);
      req_valid = 1'b1;
      req_set   = set;
      req_hit   = hit;
      req_way   = way;
      e.way      = exp_way;
      e.tree     = exp_tree;
      e.chk_tree = chk_tree;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      @(negedge clk);
      req_valid = 1'b0;
      inv_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 1'b0;
      inv_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [2:0] miss_seq [8];

   initial begin
      miss_seq = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
      rst = 1'b1;
      req_valid = 1'b0;
      req_set = '0;
      req_hit = 1'b0;
      req_way = '0;
      inv_valid = 1'b0;
      inv_set = '0;
      inv_way = '0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("reset_resp_valid", 32'(resp_valid), 32'd0);
      check("reset_resp_way", 32'(resp_way), 32'd0);
      check("reset_resp_tree", 32'(resp_tree), 32'h7f);
      check("reset_inv_ready", 32'(inv_ready), 32'd1);
      rst = 1'b0;

      // Eight misses to set 3 walk every way
      for (int i = 0; i < 8; i++) lookup(4'd3, 1'b0, 3'd0, miss_seq[i], i == 0, 7'h74);
      idle();

      // Hit then miss on set 5, set 6 independent
      lookup(4'd5, 1'b1, 3'd0, 3'd0, 1, 7'h74);
      lookup(4'd5, 1'b0, 3'd0, 3'd4);
      lookup(4'd6, 1'b0, 3'd0, 3'd0);
      idle();

      // Full sweep on set 1, then hit way 0 reorders the tree
      for (int i = 0; i < 8; i++) lookup(4'd1, 1'b0, 3'd0, miss_seq[i]);
      lookup(4'd1, 1'b1, 3'd0, 3'd0);
      lookup(4'd1, 1'b0, 3'd0, 3'd4);
      idle();

      // Idle invalidate makes way 5 the victim of set 2
      @(negedge clk);
      inv_valid = 1'b1;
      inv_set   = 4'd2;
      inv_way   = 3'd5;
      #1 check("inv_ready_idle", 32'(inv_ready), 32'd1);
      idle();
      check("inv_no_resp", 32'(resp_valid), 32'd0);
      lookup(4'd2, 1'b0, 3'd0, 3'd5, 1, 7'h7b);
      idle();

      // Collision: lookup wins, invalidate waits one cycle
      lookup(4'd4, 1'b0, 3'd0, 3'd0, 1, 7'h74);
      inv_valid = 1'b1;
      inv_set   = 4'd4;
      inv_way   = 3'd6;
      #1 check("inv_ready_blocked", 32'(inv_ready), 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      #1 check("inv_ready_retry", 32'(inv_ready), 32'd1);
      idle();
      check("inv_retry_no_resp", 32'(resp_valid), 32'd0);
      lookup(4'd4, 1'b0, 3'd0, 3'd6);
      idle();

      // Reset with a lookup pending drops the response and clears the trees
      lookup(4'd0, 1'b0, 3'd0, 3'd0);
      lookup(4'd0, 1'b0, 3'd0, 3'd4);
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 1'b1;
      req_set   = 4'd0;
      req_hit   = 1'b0;
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 1'b0;
      check("rst_drop_resp", 32'(resp_valid), 32'd0);
      check("rst_resp_tree", 32'(resp_tree), 32'h7f);
      lookup(4'd0, 1'b0, 3'd0, 3'd0, 1, 7'h74);
      idle();
      idle();
      idle();

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
